// File: rtl/clk_div_gen.sv
// -----------------------------------------------------------------------------
// clk_div_gen
//
// Run-time programmable 50%-duty divided clock with edge strobes.
//
// sclk toggles every hp_reg cycles of i_clk, so one period is 2*hp_reg
// cycles. Starting and stopping never shorten a half-period. A new divisor
// is loaded through a handshake and only takes effect on a period boundary
// (the falling toggle) while running, or right away while idle.
//
// Optional feature macro: CLKDIV_BURST_EN
//   When defined, adds i_burst_len / o_burst_done. The block then stops by
//   itself after i_burst_len rising edges of sclk and stays stopped until
//   i_en has been seen low. i_burst_len = 0 means free-running.
//
// Ports
//   i_clk         system clock, all logic on the rising edge
//   i_rst_n       asynchronous active-low reset
//   i_en          run request (level)
//   i_div_half    requested half-period in i_clk cycles (0 behaves as 1)
//   i_div_load    one-cycle strobe capturing i_div_half
//   o_div_ack     one-cycle pulse when a loaded divisor has taken effect
//   o_sclk        divided clock, idles low
//   o_sclk_rise   one-cycle pulse in the first cycle o_sclk is high
//   o_sclk_fall   one-cycle pulse in the first cycle o_sclk is low again
//   o_active      high while running or finishing the last half-period
//   i_burst_len   (CLKDIV_BURST_EN) number of rises per burst, 0 = endless
//   o_burst_done  (CLKDIV_BURST_EN) pulse together with the final fall
//
// States
//   ST_IDLE     | sclk low, counter cleared, waiting for a run request
//   ST_RUN      | counting and toggling, run request present
//   ST_STOPPING | run request gone, finishing the current half-period
// -----------------------------------------------------------------------------
module clk_div_gen #(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 100
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_div_half,
    input  logic             i_div_load,
    output logic             o_div_ack,
    output logic             o_sclk,
    output logic             o_sclk_rise,
    output logic             o_sclk_fall,
    output logic             o_active
`ifdef CLKDIV_BURST_EN
    ,
    input  logic [15:0]      i_burst_len,
    output logic             o_burst_done
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_hp;
    logic [CNT_W-1:0] w_hp_nxt;
    logic [CNT_W-1:0] r_pend;
    logic [CNT_W-1:0] w_pend_nxt;
    logic             r_pending;
    logic             w_pending_nxt;

    logic             r_sclk;
    logic             w_sclk_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;
    logic             r_active;
    logic             r_apply;
    logic             w_apply;
    logic             r_ack;

    logic             w_term;
    logic             w_run_req;
    logic [CNT_W-1:0] w_div_clamped;

    assign w_div_clamped = (i_div_half == '0) ? CNT_W'(1) : i_div_half;

    // hp_reg is never 0, so hp_reg-1 cannot underflow.
    assign w_term = (r_cnt == (r_hp - CNT_W'(1)));

`ifdef CLKDIV_BURST_EN
    logic [15:0] r_burst_cnt;
    logic        r_burst_hold;
    logic        r_burst_done;

    // Once a burst has completed, the run request is masked until i_en
    // has been observed low, which re-arms the burst counter.
    assign w_run_req = i_en & ~r_burst_hold;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_burst_cnt  <= '0;
            r_burst_hold <= 1'b0;
            r_burst_done <= 1'b0;
        end else begin
            r_burst_done <= w_fall_nxt & r_burst_hold & (w_state_nxt == ST_IDLE);
            if (!i_en) begin
                r_burst_cnt  <= '0;
                r_burst_hold <= 1'b0;
            end else if (w_rise_nxt && (i_burst_len != 16'd0)) begin
                r_burst_cnt <= r_burst_cnt + 16'd1;
                // >= keeps the burst bounded if i_burst_len is lowered mid-burst
                if ((r_burst_cnt + 16'd1) >= i_burst_len) begin
                    r_burst_hold <= 1'b1;
                end
            end
        end
    end

    assign o_burst_done = r_burst_done;
`else
    assign w_run_req = i_en;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state, half-period counter and sclk
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sclk_nxt  = r_sclk;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt  = '0;
                w_sclk_nxt = 1'b0;
                if (w_run_req) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN, ST_STOPPING: begin
                if (w_term) begin
                    w_cnt_nxt = '0;
                    if (r_sclk) begin
                        w_sclk_nxt = 1'b0;
                        w_fall_nxt = 1'b1;
                    end else if (w_run_req) begin
                        w_sclk_nxt = 1'b1;
                        w_rise_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end

                // Without a run request, the end of whichever half-period is
                // in progress is the stopping point: a high half ends with a
                // fall, a low half simply ends without a new rise.
                if (w_run_req) begin
                    w_state_nxt = ST_RUN;
                end else if (w_term) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_STOPPING;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_sclk_nxt  = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Divisor load / apply
    // -------------------------------------------------------------------------
    always_comb begin
        w_hp_nxt      = r_hp;
        w_pend_nxt    = r_pend;
        w_pending_nxt = r_pending;
        w_apply       = 1'b0;

        if (i_div_load) begin
            if (r_state == ST_IDLE) begin
                // Idle: take the value directly so that a load coinciding
                // with the run request governs the first half-period.
                w_hp_nxt      = w_div_clamped;
                w_pending_nxt = 1'b0;
                w_apply       = 1'b1;
            end else begin
                // A load landing on a boundary overwrites the pending value
                // and waits for the next boundary.
                w_pend_nxt    = w_div_clamped;
                w_pending_nxt = 1'b1;
            end
        end else if (r_pending && ((r_state == ST_IDLE) || w_fall_nxt)) begin
            w_hp_nxt      = r_pend;
            w_pending_nxt = 1'b0;
            w_apply       = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_hp      <= CNT_W'(DIV_DEFAULT);
            r_pend    <= CNT_W'(DIV_DEFAULT);
            r_pending <= 1'b0;
            r_sclk    <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_active  <= 1'b0;
            r_apply   <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_hp      <= w_hp_nxt;
            r_pend    <= w_pend_nxt;
            r_pending <= w_pending_nxt;
            r_sclk    <= w_sclk_nxt;
            r_rise    <= w_rise_nxt;
            r_fall    <= w_fall_nxt;
            r_active  <= (w_state_nxt != ST_IDLE);
            // The ack trails the divisor update by one cycle.
            r_apply   <= w_apply;
            r_ack     <= r_apply;
        end
    end

    assign o_sclk      = r_sclk;
    assign o_sclk_rise = r_rise;
    assign o_sclk_fall = r_fall;
    assign o_active    = r_active;
    assign o_div_ack   = r_ack;

endmodule

// File: tb/tb_clk_div_gen.sv
module tb_clk_div_gen;

    localparam int CNT_W = 16;
    localparam int DIVD  = 100;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             en       = 1'b0;
    logic             div_load = 1'b0;
    logic [CNT_W-1:0] div_half = '0;
    logic             div_ack;
    logic             sclk;
    logic             sclk_rise;
    logic             sclk_fall;
    logic             active;
`ifdef CLKDIV_BURST_EN
    logic [15:0]      burst_len = '0;
    logic             burst_done;
`endif

    int n_tests    = 0;
    int n_fail     = 0;
    int ack_cnt    = 0;
    int strobe_err = 0;
    logic prev_sclk = 1'b0;

    always #5 clk = ~clk;

    clk_div_gen #(.CNT_W(CNT_W), .DIV_DEFAULT(DIVD)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_div_half  (div_half),
        .i_div_load  (div_load),
        .o_div_ack   (div_ack),
        .o_sclk      (sclk),
        .o_sclk_rise (sclk_rise),
        .o_sclk_fall (sclk_fall),
        .o_active    (active)
`ifdef CLKDIV_BURST_EN
        ,
        .i_burst_len (burst_len),
        .o_burst_done(burst_done)
`endif
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // One clock: sample 1 ns after the rising edge, track strobe shape.
    task automatic tick();
        @(posedge clk);
        #1;
        if (div_ack) ack_cnt++;
        if ((sclk_rise !== (sclk & ~prev_sclk)) || (sclk_fall !== (~sclk & prev_sclk)))
            strobe_err++;
        prev_sclk = sclk;
    endtask

    task automatic wait_edge(input bit want_rise, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (want_rise ? sclk_rise : sclk_fall) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        en       = 1'b0;
        div_load = 1'b0;
        div_half = '0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        prev_sclk = 1'b0;
        tick();
    endtask

    // ---------------- reference model ----------------
    // Tracks absolute cycle time and the cycle at which the current
    // half-period ends, plus the divisor handshake.
    int   m_t, m_deadline, m_hp, m_pend;
    bit   m_act, m_sclk, m_rise, m_fall, m_pending, m_apply_prev, m_ack;

    task automatic model_init();
        m_t = 0; m_deadline = 0; m_hp = DIVD; m_pend = DIVD;
        m_act = 0; m_sclk = 0; m_rise = 0; m_fall = 0;
        m_pending = 0; m_apply_prev = 0; m_ack = 0;
    endtask

    task automatic model_step(input bit i_en, input bit i_ld, input int i_dh);
        bit was_act;
        bit fell;
        bit apply;
        int nh;
        was_act = m_act;
        fell    = 0;
        apply   = 0;
        m_t++;
        m_rise = 0;
        m_fall = 0;
        if (was_act && (m_t == m_deadline)) begin
            if (m_sclk) begin
                m_sclk = 0; m_fall = 1; fell = 1;
                if (!i_en) m_act = 0;
            end else if (i_en) begin
                m_sclk = 1; m_rise = 1;
            end else begin
                m_act = 0;
            end
        end
        nh = (i_dh == 0) ? 1 : i_dh;
        if (i_ld) begin
            if (!was_act) begin
                m_hp = nh; m_pending = 0; apply = 1;
            end else begin
                m_pend = nh; m_pending = 1;
            end
        end else if (m_pending && (!was_act || fell)) begin
            m_hp = m_pend; m_pending = 0; apply = 1;
        end
        if (!was_act && i_en) begin
            m_act = 1;
            m_deadline = m_t + m_hp;
        end else if (was_act && m_act && (m_t == m_deadline)) begin
            m_deadline = m_t + m_hp;
        end
        m_ack = m_apply_prev;
        m_apply_prev = apply;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          en;
        bit          ld;
        logic [15:0] dh;
        logic [4:0]  exp;   // {sclk, rise, fall, active, ack}
    } vec_t;

    vec_t tbl[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt_a;
        int cnt_b;

        tbl[0]  = '{1'b0, 1'b1, 16'd2, 5'b00000};
        tbl[1]  = '{1'b1, 1'b0, 16'd0, 5'b00011};
        tbl[2]  = '{1'b1, 1'b0, 16'd0, 5'b00010};
        tbl[3]  = '{1'b1, 1'b0, 16'd0, 5'b11010};
        tbl[4]  = '{1'b1, 1'b0, 16'd0, 5'b10010};
        tbl[5]  = '{1'b1, 1'b0, 16'd0, 5'b00110};
        tbl[6]  = '{1'b0, 1'b0, 16'd0, 5'b00010};
        tbl[7]  = '{1'b0, 1'b0, 16'd0, 5'b00000};
        tbl[8]  = '{1'b1, 1'b1, 16'd0, 5'b00010};
        tbl[9]  = '{1'b1, 1'b0, 16'd0, 5'b11011};
        tbl[10] = '{1'b1, 1'b0, 16'd0, 5'b00110};
        tbl[11] = '{1'b1, 1'b0, 16'd0, 5'b11010};
        tbl[12] = '{1'b0, 1'b0, 16'd0, 5'b00100};
        tbl[13] = '{1'b0, 1'b0, 16'd0, 5'b00000};

        // ---- reset values ----
        #3;
        check("in_reset_outs", {sclk, sclk_rise, sclk_fall, active, div_ack}, 0);
        do_reset();
        check("after_reset_outs", {sclk, sclk_rise, sclk_fall, active, div_ack}, 0);

        // ---- table: hp=2 start/stop, hp=0->1 load with en ----
        for (int i = 0; i < 14; i++) begin
            en       = tbl[i].en;
            div_load = tbl[i].ld;
            div_half = tbl[i].dh;
            tick();
            check($sformatf("vec%0d", i),
                  {sclk, sclk_rise, sclk_fall, active, div_ack}, tbl[i].exp);
        end
        div_load = 1'b0;

        // ---- default divisor after reset ----
        do_reset();
        en = 1'b1;
        tick();
        wait_edge(1, 300, n); check("dflt_first_rise", n, 100);
        wait_edge(0, 300, n); check("dflt_high", n, 100);
        wait_edge(1, 300, n); check("dflt_low", n, 100);

        // ---- divisor change 4 -> 7 -> (9,3) ----
        do_reset();
        div_half = 16'd4; div_load = 1'b1;
        tick();
        div_load = 1'b0; en = 1'b1;
        tick();
        ack_cnt = 0;
        wait_edge(1, 50, n); check("hp4_low", n, 4);
        tick();
        div_half = 16'd7; div_load = 1'b1;
        tick();
        div_load = 1'b0;
        wait_edge(0, 50, n); check("hp4_high_kept", n + 2, 4);
        wait_edge(1, 50, n); check("hp7_low", n, 7);
        check("ack_once_7", ack_cnt, 1);
        ack_cnt = 0;
        tick();
        div_half = 16'd9; div_load = 1'b1;
        tick();
        div_half = 16'd3;
        tick();
        div_load = 1'b0;
        wait_edge(0, 50, n); check("hp7_high_kept", n + 3, 7);
        wait_edge(1, 50, n); check("hp3_low", n, 3);
        wait_edge(0, 50, n); check("hp3_high", n, 3);
        check("ack_once_3", ack_cnt, 1);

        // ---- div_half = 0 behaves as 1 ----
        do_reset();
        div_half = 16'd0; div_load = 1'b1;
        tick();
        div_load = 1'b0; en = 1'b1;
        tick();
        wait_edge(1, 10, n); check("hp1_first_rise", n, 1);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 6; i++) begin
            logic s0;
            s0 = sclk;
            tick();
            if (sclk != s0) cnt_a++;
            if (sclk_rise) cnt_b++;
        end
        check("hp1_toggles", cnt_a, 6);
        check("hp1_rises", cnt_b, 3);

        // ---- stop in high phase, then resume during STOPPING ----
        do_reset();
        div_half = 16'd5; div_load = 1'b1;
        tick();
        div_load = 1'b0; en = 1'b1;
        tick();
        wait_edge(1, 50, n); check("stop_low", n, 5);
        tick(); tick();
        en = 1'b0;
        wait_edge(0, 50, n); check("stop_high_full", n + 2, 5);
        tick();
        check("stop_active_low", {active, sclk}, 0);
        cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sclk || active || sclk_rise) cnt_a++;
        end
        check("stop_quiet", cnt_a, 0);
        en = 1'b1;
        tick();
        wait_edge(1, 50, n); check("resume_low", n, 5);
        tick();
        en = 1'b0;
        tick(); tick();
        en = 1'b1;
        wait_edge(0, 50, n); check("resume_high_nogap", n + 3, 5);
        wait_edge(1, 50, n); check("resume_low_nogap", n, 5);
        check("resume_active", active, 1);

        // ---- asynchronous reset mid-high ----
        tick(); tick();
        check("pre_rst_high", sclk, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outs", {sclk, sclk_rise, sclk_fall, active, div_ack}, 0);
        en = 1'b0;
        #1 rst_n = 1'b1;
        prev_sclk = 1'b0;
        tick();
        en = 1'b1;
        tick();
        wait_edge(1, 300, n); check("rst_hp_default", n, 100);

`ifdef CLKDIV_BURST_EN
        // ---- burst of 8 rises at hp=2 ----
        do_reset();
        burst_len = 16'd8;
        div_half = 16'd2; div_load = 1'b1;
        tick();
        div_load = 1'b0; en = 1'b1;
        cnt_a = 0; cnt_b = 0; n = 0;
        begin
            int done_cnt;
            int fall_at_done;
            done_cnt = 0; fall_at_done = -1;
            for (int i = 0; i < 200; i++) begin
                tick();
                if (sclk_rise) cnt_a++;
                if (sclk_fall) cnt_b++;
                if (burst_done) begin
                    done_cnt++;
                    fall_at_done = sclk_fall ? cnt_b : -1;
                end
            end
            check("burst_rises", cnt_a, 8);
            check("burst_done_once", done_cnt, 1);
            check("burst_done_on_8th_fall", fall_at_done, 8);
            check("burst_inactive", active, 0);
        end
        tick();
        en = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (sclk_rise || active) cnt_a++;
        end
        check("burst_no_rearm", cnt_a, 0);
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        wait_edge(1, 50, n); check("burst_rearm_rise", n, 2);
        burst_len = 16'd0;
`endif

        // ---- randomized run against the model ----
        do_reset();
        model_init();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) en = ~en;
            div_load = ($urandom_range(0, 15) == 0);
            div_half = 16'($urandom_range(0, 6));
            tick();
            model_step(en, div_load, int'(div_half));
            check($sformatf("rand_cyc%0d", i),
                  {sclk, sclk_rise, sclk_fall, active, div_ack},
                  {m_sclk, m_rise, m_fall, m_act, m_ack});
        end
        div_load = 1'b0;

        check("strobe_shape", strobe_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
